simple_xnor: RTL and testbench

//  3-input XNOR (even-parity detector) primitive for the logic-lab datapath.
//  - Combinational result for direct gate-level use.
//  - Registered copy with a valid flag, plus a saturating count of cycles

---
 rtl/simple_xnor_pkg.sv | 19 +
 rtl/simple_xnor_xnor3_bit.sv | 19 +
 rtl/simple_xnor.sv | 89 ++++++++
 tb/tb_simple_xnor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/simple_xnor_pkg.sv
// -----------------------------------------------------------------------------
// simple_xnor_pkg
//   Shared defaults and the single-bit XNOR helper for the simple_xnor block.
//   Contents:
//     DefaultWidth - default operand/result width
//     DefaultCntW  - default width of the true-cycle counter
//     xnor3()      - ~(a ^ b ^ c) on one bit (even-parity of three inputs)
// -----------------------------------------------------------------------------
package simple_xnor_pkg;

   localparam int unsigned DefaultWidth = 1;
   localparam int unsigned DefaultCntW  = 8;

   // High when an even number (0 or 2) of the three inputs are set.
   function automatic logic xnor3(input logic a, input logic b, input logic c);
      return ~(a ^ b ^ c);
   endfunction

endpackage : simple_xnor_pkg

// File: rtl/simple_xnor_xnor3_bit.sv
// -----------------------------------------------------------------------------
// xnor3_bit
//   Single-bit combinational three-input XNOR cell (even-parity detector).
//   Ports:
//     a_i, b_i, c_i - operand bits
//     y_o           - ~(a_i ^ b_i ^ c_i)
// -----------------------------------------------------------------------------
module xnor3_bit
   import simple_xnor_pkg::*;
(
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic y_o
);

   assign y_o = xnor3(a_i, b_i, c_i);

endmodule : xnor3_bit

// File: rtl/simple_xnor.sv
// -----------------------------------------------------------------------------
// simple_xnor
//   Bitwise three-input XNOR with a combinational result, a registered copy
//   with a one-cycle valid pulse, and a saturating count of sampled cycles
//   whose bit-0 result was true.
//   Parameters:
//     WIDTH - width of a, b, c, result and result_q
//     CNT_W - width of true_cnt
//   Ports:
//     clk       - clock, all state updates on the rising edge
//     rst       - synchronous active-high reset
//     a, b, c   - operands
//     result    - combinational ~(a ^ b ^ c), per bit
//     in_valid  - sample a/b/c this cycle
//     result_q  - registered result of the last sampled inputs
//     out_valid - one-cycle pulse: result_q holds a fresh sample
//     true_cnt  - sampled cycles with result[0] == 1, saturating
// -----------------------------------------------------------------------------
module simple_xnor
   import simple_xnor_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned CNT_W = DefaultCntW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] result,
   input  logic             in_valid,
   output logic [WIDTH-1:0] result_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] true_cnt
);

   // ---------------------------------------------------------------------------
   // Combinational datapath: one cell per bit
   // ---------------------------------------------------------------------------
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      xnor3_bit u_cell (
         .a_i (a[gi]),
         .b_i (b[gi]),
         .c_i (c[gi]),
         .y_o (result[gi])
      );
   end

   // ---------------------------------------------------------------------------
   // Register stage and saturating counter
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] res_d, res_q;
   logic             valid_d, valid_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             cnt_full;

   assign cnt_full = &cnt_q;

   always_comb begin
      res_d   = res_q;
      valid_d = 1'b0;
      cnt_d   = cnt_q;
      if (in_valid) begin
         res_d   = result;
         valid_d = 1'b1;
         // Count only bit 0; stick at all-ones rather than wrap.
         if (result[0] && !cnt_full) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         res_q   <= res_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign result_q  = res_q;
   assign out_valid = valid_q;
   assign true_cnt  = cnt_q;

endmodule : simple_xnor

// File: tb/tb_simple_xnor.sv
// Self-checking bench for simple_xnor: three instances (1-bit, 1-bit with a
// 2-bit counter, 4-bit) share clock and reset.
module tb_simple_xnor;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 1-bit, CNT_W=8
   logic       a_a, b_a, c_a, vld_a;
   logic       res_a, resq_a, ov_a;
   logic [7:0] cnt_a;
   // 1-bit, CNT_W=2
   logic       a_s, b_s, c_s, vld_s;
   logic       res_s, resq_s, ov_s;
   logic [1:0] cnt_s;
   // 4-bit, CNT_W=4
   logic [3:0] a_v, b_v, c_v;
   logic       vld_v;
   logic [3:0] res_v, resq_v;
   logic       ov_v;
   logic [3:0] cnt_v;

   simple_xnor #(.WIDTH(1), .CNT_W(8)) u_dut_a (
      .clk(clk), .rst(rst), .a(a_a), .b(b_a), .c(c_a), .result(res_a),
      .in_valid(vld_a), .result_q(resq_a), .out_valid(ov_a), .true_cnt(cnt_a)
   );
   simple_xnor #(.WIDTH(1), .CNT_W(2)) u_dut_s (
      .clk(clk), .rst(rst), .a(a_s), .b(b_s), .c(c_s), .result(res_s),
      .in_valid(vld_s), .result_q(resq_s), .out_valid(ov_s), .true_cnt(cnt_s)
   );
   simple_xnor #(.WIDTH(4), .CNT_W(4)) u_dut_v (
      .clk(clk), .rst(rst), .a(a_v), .b(b_v), .c(c_v), .result(res_v),
      .in_valid(vld_v), .result_q(resq_v), .out_valid(ov_v), .true_cnt(cnt_v)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a bit is 1 when an even number of the three inputs are 1.
   function automatic logic [3:0] ref4(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) begin
         int ones;
         ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
         r[i] = (ones % 2 == 0);
      end
      return r;
   endfunction

   // Scoreboard for the 4-bit instance
   typedef struct packed {
      logic [3:0] res;
      logic [3:0] cnt;
   } exp_t;
   exp_t       sb_q[$];
   int         cnt_m = 0;
   logic [3:0] last_res = '0;
   logic [3:0] last_cnt = '0;
   bit         mon_en = 1'b0;

   task automatic drive_v(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic vld);
      logic [3:0] e;
      exp_t       item;
      @(negedge clk);
      a_v = a; b_v = b; c_v = c; vld_v = vld;
      e = ref4(a, b, c);
      #1;
      chk("v_result_comb", 32'(res_v), 32'(e));
      if (vld) begin
         if (e[0] && cnt_m != 15) cnt_m++;
         item.res = e;
         item.cnt = 4'(cnt_m);
         sb_q.push_back(item);
      end
   endtask

   // Monitor: pops one expectation per out_valid pulse, otherwise expects hold.
   always @(posedge clk) begin
      exp_t item;
      #1;
      if (mon_en) begin
         if (ov_v) begin
            if (sb_q.size() == 0) begin
               chk("v_unexpected_valid", 32'(ov_v), 32'(0));
            end else begin
               item = sb_q.pop_front();
               chk("v_result_q", 32'(resq_v), 32'(item.res));
               chk("v_true_cnt", 32'(cnt_v), 32'(item.cnt));
               last_res = item.res;
               last_cnt = item.cnt;
            end
         end else begin
            chk("v_missing_valid", 32'(sb_q.size()), 32'(0));
            chk("v_hold_result_q", 32'(resq_v), 32'(last_res));
            chk("v_hold_true_cnt", 32'(cnt_v), 32'(last_cnt));
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1);
   end

   initial begin
      logic [7:0] tbl;
      logic [2:0] v;
      tbl = 8'b0110_1001;  // bit i = result for abc == i

      // Reset for 2 edges with in_valid high and zero inputs.
      rst = 1'b1;
      a_a = 0; b_a = 0; c_a = 0; vld_a = 1;
      a_s = 0; b_s = 0; c_s = 0; vld_s = 1;
      a_v = '0; b_v = '0; c_v = '0; vld_v = 1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_result_live", 32'(res_a), 32'(1));
      end
      chk("rst_result_q", 32'(resq_a), 32'(0));
      chk("rst_out_valid", 32'(ov_a), 32'(0));
      chk("rst_true_cnt", 32'(cnt_a), 32'(0));
      chk("rst_v_true_cnt", 32'(cnt_v), 32'(0));
      chk("rst_s_out_valid", 32'(ov_s), 32'(0));
      @(negedge clk);
      rst = 1'b0; vld_a = 0; vld_s = 0; vld_v = 0;
      mon_en = 1'b1;

      // Exhaustive combinational truth table.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         a_a = v[2]; b_a = v[1]; c_a = v[0];
         #100;
         chk($sformatf("comb_tt_%0d", i), 32'(res_a), 32'(tbl[i]));
      end
      chk("comb_no_sample_cnt", 32'(cnt_a), 32'(0));

      // Pipeline: 8 back-to-back samples, result_q lags by one edge.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         v = 3'(i);
         a_a = v[2]; b_a = v[1]; c_a = v[0]; vld_a = 1;
         @(posedge clk);
         #1;
         chk($sformatf("pipe_result_q_%0d", i), 32'(resq_a), 32'(tbl[i]));
         chk($sformatf("pipe_out_valid_%0d", i), 32'(ov_a), 32'(1));
      end
      @(negedge clk);
      vld_a = 0;
      @(posedge clk);
      #1;
      chk("pipe_valid_drop", 32'(ov_a), 32'(0));
      chk("pipe_true_cnt", 32'(cnt_a), 32'(4));

      // Hold: inputs toggle with in_valid low.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         v = 3'($urandom_range(0, 7));
         a_a = v[2]; b_a = v[1]; c_a = v[0];
         #1;
         chk("hold_result_comb", 32'(res_a), 32'(tbl[v]));
         @(posedge clk);
         #1;
         chk("hold_result_q", 32'(resq_a), 32'(tbl[7]));
         chk("hold_true_cnt", 32'(cnt_a), 32'(4));
         chk("hold_out_valid", 32'(ov_a), 32'(0));
      end

      // Saturation with a 2-bit counter.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         a_s = 0; b_s = 0; c_s = 0; vld_s = 1;
         @(posedge clk);
         #1;
         chk($sformatf("sat_cnt_%0d", k), 32'(cnt_s), 32'((k + 1 > 3) ? 3 : k + 1));
      end
      @(negedge clk);
      vld_s = 0;

      // Vector case, then randomized traffic through the scoreboard.
      drive_v(4'b0011, 4'b0101, 4'b0000, 1'b1);
      chk("vec_result_comb", 32'(res_v), 32'(4'b1001));
      for (int i = 0; i < 90; i++) begin
         drive_v(4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
      end
      chk("v_model_reached_sat", 32'(cnt_m), 32'(15));

      // Mid-run reset: wins over in_valid and clears a nonzero count.
      @(negedge clk);
      mon_en = 1'b0;
      rst = 1'b1; vld_v = 1; a_v = '0; b_v = '0; c_v = '0;
      @(posedge clk);
      #1;
      chk("rst2_true_cnt", 32'(cnt_v), 32'(0));
      chk("rst2_out_valid", 32'(ov_v), 32'(0));
      chk("rst2_result_q", 32'(resq_v), 32'(0));
      @(negedge clk);
      rst = 1'b0; vld_v = 0;
      sb_q.delete();
      cnt_m = 0; last_res = '0; last_cnt = '0;
      mon_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive_v(4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 1) != 0);
      end
      drive_v('0, '0, '0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      chk("sb_drained", 32'(sb_q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_simple_xnor
